// File: rtl/dcfir_coe_seq_if.sv
// Control, coefficient-write and tap-output bundle for dcfir_coe_seq.
// DCFIR_COE_READBACK_EN adds the coe_rdata readback lane.
interface dcfir_coe_seq_if;
  logic        start;
  logic        abort;
  logic        cont;
  logic        coe_we;
  logic [4:0]  coe_addr;
  logic [19:0] coe_wdata;
  logic [5:0]  sel;
  logic [9:0]  coe_real1;
  logic [9:0]  coe_real2;
  logic [9:0]  coe_real3;
  logic [9:0]  coe_real4;
  logic [9:0]  coe_imag1;
  logic [9:0]  coe_imag2;
  logic [9:0]  coe_imag3;
  logic [9:0]  coe_imag4;
  logic        tap_valid;
  logic        busy;
  logic        done;
  logic        coe_err;
`ifdef DCFIR_COE_READBACK_EN
  logic [19:0] coe_rdata;

  modport master (
    output start, abort, cont, coe_we, coe_addr, coe_wdata,
    input  sel, coe_real1, coe_real2, coe_real3, coe_real4,
    input  coe_imag1, coe_imag2, coe_imag3, coe_imag4,
    input  tap_valid, busy, done, coe_err, coe_rdata
  );

  modport slave (
    input  start, abort, cont, coe_we, coe_addr, coe_wdata,
    output sel, coe_real1, coe_real2, coe_real3, coe_real4,
    output coe_imag1, coe_imag2, coe_imag3, coe_imag4,
    output tap_valid, busy, done, coe_err, coe_rdata
  );
`else
  modport master (
    output start, abort, cont, coe_we, coe_addr, coe_wdata,
    input  sel, coe_real1, coe_real2, coe_real3, coe_real4,
    input  coe_imag1, coe_imag2, coe_imag3, coe_imag4,
    input  tap_valid, busy, done, coe_err
  );

  modport slave (
    input  start, abort, cont, coe_we, coe_addr, coe_wdata,
    output sel, coe_real1, coe_real2, coe_real3, coe_real4,
    output coe_imag1, coe_imag2, coe_imag3, coe_imag4,
    output tap_valid, busy, done, coe_err
  );
`endif
endinterface

// File: rtl/dcfir_coe_seq.sv
// Coefficient bank and frame sequencer feeding sel/coefficient lanes to the D-CFIR VMM stage.
// Optional DCFIR_COE_READBACK_EN adds a registered bank readback port (coe_rdata).
module dcfir_coe_seq #(
  parameter int unsigned NTAPS    = 32,
  parameter int unsigned PIPE_LAT = 4
) (
  input logic            CLK,
  input logic            rst_n,
  dcfir_coe_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  localparam logic [4:0] KLast   = 5'(NTAPS - 1);
  localparam logic [3:0] CntInit = 4'(PIPE_LAT - 1);

  state_e      state_q, state_d;
  logic [4:0]  k_q, k_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wrap_q, wrap_d;
  logic        fin_d;
  logic [19:0] bank_q [32];

  logic [5:0]  sel_q, sel_d;
  logic [19:0] lane_q [4];
  logic [19:0] lane_d [4];
  logic        tap_valid_q, tap_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        coe_err_q, coe_err_d;
  logic        run;
  logic        bank_we;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    fin_d   = 1'b0;
    if (bus.abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_d = StRun;
            k_d     = '0;
          end
        end
        StRun: begin
          if (k_q == KLast) begin
            if (bus.cont) begin
              k_d    = '0;
              wrap_d = 1'b1;
            end else begin
              state_d = StDrain;
              cnt_d   = CntInit;
            end
          end else begin
            k_d = k_q + 5'd1;
          end
        end
        StDrain: begin
          if (cnt_q == 4'd0) begin
            state_d = StIdle;
            fin_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Tap outputs trail the state register by one edge; abort zeroes them at its own edge.
  always_comb begin
    run         = (state_q == StRun) && !bus.abort;
    sel_d       = run ? {1'b0, k_q} : 6'd0;
    tap_valid_d = run;
    for (int n = 0; n < 4; n++) begin
      lane_d[n] = '0;
      if (run && (k_q >= 5'(n))) begin
        lane_d[n] = bank_q[k_q - 5'(n)];
      end
    end
    busy_d    = (state_d != StIdle);
    // Continuous-mode done lines up with the wrapped sel=0 output cycle.
    done_d    = fin_d || (wrap_q && !bus.abort);
    bank_we   = bus.coe_we && (state_q == StIdle);
    coe_err_d = bus.coe_we && (state_q != StIdle);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      k_q         <= '0;
      cnt_q       <= '0;
      wrap_q      <= 1'b0;
      sel_q       <= '0;
      tap_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      coe_err_q   <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        lane_q[n] <= '0;
      end
      for (int i = 0; i < 32; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      wrap_q      <= wrap_d;
      sel_q       <= sel_d;
      tap_valid_q <= tap_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      coe_err_q   <= coe_err_d;
      for (int n = 0; n < 4; n++) begin
        lane_q[n] <= lane_d[n];
      end
      if (bank_we) begin
        bank_q[bus.coe_addr] <= bus.coe_wdata;
      end
    end
  end

`ifdef DCFIR_COE_READBACK_EN
  logic [19:0] rdata_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= bank_q[bus.coe_addr];
    end
  end

  assign bus.coe_rdata = rdata_q;
`endif

  assign bus.sel       = sel_q;
  assign bus.tap_valid = tap_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.coe_err   = coe_err_q;
  assign bus.coe_real1 = lane_q[0][19:10];
  assign bus.coe_real2 = lane_q[1][19:10];
  assign bus.coe_real3 = lane_q[2][19:10];
  assign bus.coe_real4 = lane_q[3][19:10];
  assign bus.coe_imag1 = lane_q[0][9:0];
  assign bus.coe_imag2 = lane_q[1][9:0];
  assign bus.coe_imag3 = lane_q[2][9:0];
  assign bus.coe_imag4 = lane_q[3][9:0];

endmodule

// File: tb/tb_dcfir_coe_seq.sv
// Directed bench for dcfir_coe_seq: a 32-tap/4-drain instance and a 4-tap/1-drain instance.
module tb_dcfir_coe_seq;

  logic CLK;
  logic rst_n;
  int   tests;
  int   fails;

  dcfir_coe_seq_if bus ();
  dcfir_coe_seq_if bus4 ();

  dcfir_coe_seq #(.NTAPS(32), .PIPE_LAT(4)) u_dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  dcfir_coe_seq #(.NTAPS(4), .PIPE_LAT(1)) u_dut4 (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [9:0] r;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;  bus.abort = 1'b0;  bus.cont = 1'b0;
    bus.coe_we = 1'b0; bus.coe_addr = '0; bus.coe_wdata = '0;
    bus4.start = 1'b0; bus4.abort = 1'b0; bus4.cont = 1'b0;
    bus4.coe_we = 1'b0; bus4.coe_addr = '0; bus4.coe_wdata = '0;

    // Reset state
    step();
    step();
    chk("rst_sel", bus.sel, 0);
    chk("rst_tap_valid", bus.tap_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_real1", bus.coe_real1, 0);
    chk("rst_b4_busy", bus4.busy, 0);
    rst_n = 1'b1;
    step();

    // bank[0] = {3FF, 001}, start, then reset in the middle of the frame
    bus.coe_we = 1'b1; bus.coe_addr = 5'd0; bus.coe_wdata = {10'h3FF, 10'h001};
    bus.start = 1'b1;
    step();
    bus.coe_we = 1'b0; bus.start = 1'b0;
    step();
    chk("pre_rst_sel", bus.sel, 0);
    chk("pre_rst_real1", bus.coe_real1, 10'h3FF);
    chk("pre_rst_imag1", bus.coe_imag1, 10'h001);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tap_valid", bus.tap_valid, 0);
    chk("async_rst_sel", bus.sel, 0);
    chk("async_rst_real1", bus.coe_real1, 0);
    chk("async_rst_busy", bus.busy, 0);
    step();
    rst_n = 1'b1;
    step();
`ifdef DCFIR_COE_READBACK_EN
    chk("rdata_after_rst", bus.coe_rdata, 0);
`endif
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("post_rst_sel", bus.sel, 0);
    chk("post_rst_tap_valid", bus.tap_valid, 1);
    chk("post_rst_real1", bus.coe_real1, 0);
    chk("post_rst_imag1", bus.coe_imag1, 0);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;

    // Load bank[i] = {i, ~i}
    for (int i = 0; i < 32; i++) begin
      r = 10'(i);
      bus.coe_we = 1'b1; bus.coe_addr = 5'(i); bus.coe_wdata = {r, ~r};
      step();
    end
    bus.coe_we = 1'b0;

    // Single frame with a rejected write in the middle
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int j = 0; j < 32; j++) begin
      step();
      chk("frame_sel", bus.sel, j);
      chk("frame_tap_valid", bus.tap_valid, 1);
      if (j == 1) begin
        chk("k1_imag2", bus.coe_imag2, 10'h3FF);
        chk("k1_real3", bus.coe_real3, 0);
        chk("k1_real4", bus.coe_real4, 0);
        chk("k1_imag3", bus.coe_imag3, 0);
      end
      if (j == 5) begin
        chk("k5_real1", bus.coe_real1, 5);
        chk("k5_real2", bus.coe_real2, 4);
        chk("k5_real3", bus.coe_real3, 3);
        chk("k5_real4", bus.coe_real4, 2);
        chk("k5_imag1", bus.coe_imag1, 10'h3FA);
      end
      if (j == 10) begin
        bus.coe_we = 1'b1; bus.coe_addr = 5'd3; bus.coe_wdata = 20'h12345;
      end
      if (j == 11) begin
        chk("busy_write_err", bus.coe_err, 1);
        bus.coe_we = 1'b0;
      end
      if (j == 12) chk("busy_write_err_pulse", bus.coe_err, 0);
    end
    for (int d = 0; d < 3; d++) begin
      step();
      chk("drain_busy", bus.busy, 1);
      chk("drain_tap_valid", bus.tap_valid, 0);
      chk("drain_done", bus.done, 0);
    end
    step();
    chk("frame_done", bus.done, 1);
    chk("frame_done_busy", bus.busy, 0);
    chk("frame_done_sel", bus.sel, 0);
    step();
    chk("frame_done_pulse", bus.done, 0);

    // Continuous mode, then abort at sel=17 with start on the same edge
    bus.cont = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 0; c < 82; c++) begin
      step();
      chk("cont_sel", bus.sel, c % 32);
      chk("cont_tap_valid", bus.tap_valid, 1);
      chk("cont_done", bus.done, (c >= 32) && (c % 32 == 0));
      if (c == 3) begin
        chk("bank3_real_kept", bus.coe_real1, 3);
        chk("bank3_imag_kept", bus.coe_imag1, 10'h3FC);
      end
    end
    chk("abort_point_sel", bus.sel, 17);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    step();
    bus.abort = 1'b0; bus.start = 1'b0; bus.cont = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_tap_valid", bus.tap_valid, 0);
    chk("abort_sel", bus.sel, 0);
    chk("abort_real1", bus.coe_real1, 0);
    chk("abort_done", bus.done, 0);
    step();
    chk("abort_idle_busy", bus.busy, 0);
    chk("abort_idle_done", bus.done, 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("restart_sel", bus.sel, 0);
    chk("restart_tap_valid", bus.tap_valid, 1);
    chk("restart_imag1", bus.coe_imag1, 10'h3FF);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;

    // NTAPS=4, PIPE_LAT=1 with start held high: 6-cycle period
    bus4.start = 1'b1;
    step();
    for (int c = 0; c < 12; c++) begin
      step();
      if (c % 6 < 4) begin
        chk("b4_sel", bus4.sel, c % 6);
        chk("b4_tap_valid", bus4.tap_valid, 1);
        chk("b4_done", bus4.done, 0);
      end else if (c % 6 == 4) begin
        chk("b4_done", bus4.done, 1);
        chk("b4_done_busy", bus4.busy, 0);
        chk("b4_done_tap_valid", bus4.tap_valid, 0);
      end else begin
        chk("b4_restart_busy", bus4.busy, 1);
        chk("b4_restart_tap_valid", bus4.tap_valid, 0);
        chk("b4_restart_done", bus4.done, 0);
      end
    end
    bus4.start = 1'b0;
    bus4.abort = 1'b1;
    step();
    bus4.abort = 1'b0;
    chk("b4_abort_busy", bus4.busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
